// File: rtl/amoa_pkg.sv
// Shared types and width helpers for the A-MOA multi-operand adder datapath.
package amoa_pkg;

  // Outputs of one approximate 4:2 compressor column
  typedef struct packed {
    logic s;
    logic c;
    logic e;
  } cell_out_t;

  // Width of the per-result error magnitude
  function automatic int unsigned apx_err_w(input int unsigned apx_bits);
    return apx_bits + 1;
  endfunction

  // Width of the four-operand sum
  function automatic int unsigned sum_w(input int unsigned w);
    return w + 2;
  endfunction

endpackage

// File: rtl/apx_cprs42_cell.sv
// Approximate 4:2 compressor column: exact for 0..3 ones, reports 2 and flags e for 4 ones.
module apx_cprs42_cell (
  input  logic x1,
  input  logic x2,
  input  logic x3,
  input  logic x4,
  output logic s,
  output logic c,
  output logic e
);

  logic p12;
  logic p34;
  logic g12;
  logic g34;

  // Pairwise propagate/generate, then merge into sum, carry and error flag
  always_comb begin
    p12 = x1 ^ x2;
    p34 = x3 ^ x4;
    g12 = x1 & x2;
    g34 = x3 & x4;
    s   = p12 ^ p34;
    c   = (p12 & p34) | g12 | g34;
    e   = g12 & g34;
  end

endmodule

// File: rtl/apx_moa4_pipe.sv
// Two-stage pipelined four-operand adder with approximate low columns,
// exact error magnitude per result and a saturating error-event counter.
module apx_moa4_pipe
  import amoa_pkg::*;
#(
  parameter int unsigned W         = 16,
  parameter int unsigned APX_BITS  = 8,
  parameter int unsigned ERR_CNT_W = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [W-1:0]         x1,
  input  logic [W-1:0]         x2,
  input  logic [W-1:0]         x3,
  input  logic [W-1:0]         x4,
  input  logic                 apx_en,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [W+1:0]         sum,
  output logic [APX_BITS:0]    err_mag,
  output logic                 err_any,
  input  logic                 stat_clr,
  output logic [ERR_CNT_W-1:0] err_cnt
);

  localparam int unsigned SUM_W = sum_w(W);
  localparam int unsigned ERR_W = apx_err_w(APX_BITS);
  localparam int unsigned HI_W  = W - APX_BITS;
  localparam int unsigned H_W   = HI_W + 2;

  logic                adv_c;
  cell_out_t           cell_o [APX_BITS];
  logic [APX_BITS-1:0] s_c;
  logic [APX_BITS-1:0] c_c;
  logic [APX_BITS-1:0] e_c;
  logic [H_W-1:0]      h_c;

  logic                s1_valid_d, s1_valid_q;
  logic [APX_BITS-1:0] s1_s_d,     s1_s_q;
  logic [APX_BITS-1:0] s1_c_d,     s1_c_q;
  logic [APX_BITS-1:0] s1_e_d,     s1_e_q;
  logic [APX_BITS-1:0] s1_fix_d,   s1_fix_q;
  logic [H_W-1:0]      s1_h_d,     s1_h_q;

  logic                 out_valid_d, out_valid_q;
  logic [SUM_W-1:0]     sum_d,       sum_q;
  logic [ERR_W-1:0]     err_mag_d,   err_mag_q;
  logic                 err_any_d,   err_any_q;
  logic [ERR_CNT_W-1:0] err_cnt_d,   err_cnt_q;

  // One compressor cell per approximate column
  for (genvar g = 0; g < int'(APX_BITS); g++) begin : g_cell
    apx_cprs42_cell u_cell (
      .x1 (x1[g]),
      .x2 (x2[g]),
      .x3 (x3[g]),
      .x4 (x4[g]),
      .s  (cell_o[g].s),
      .c  (cell_o[g].c),
      .e  (cell_o[g].e)
    );
    assign s_c[g] = cell_o[g].s;
    assign c_c[g] = cell_o[g].c;
    assign e_c[g] = cell_o[g].e;
  end

  // Exact sum of the upper columns; empty when every column is approximate
  if (HI_W > 0) begin : g_hi
    always_comb begin
      h_c = H_W'(x1[W-1:APX_BITS]) + H_W'(x2[W-1:APX_BITS])
          + H_W'(x3[W-1:APX_BITS]) + H_W'(x4[W-1:APX_BITS]);
    end
  end else begin : g_no_hi
    assign h_c = '0;
  end

  // Both stages move together whenever the output slot is free or being drained
  assign adv_c    = !out_valid_q | out_ready;
  assign in_ready = adv_c;

  // Stage 1: in exact mode the lost weight of a 4-count column is kept as a fix-up, not an error
  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_s_d     = s1_s_q;
    s1_c_d     = s1_c_q;
    s1_e_d     = s1_e_q;
    s1_fix_d   = s1_fix_q;
    s1_h_d     = s1_h_q;
    if (adv_c) begin
      s1_valid_d = in_valid;
      s1_s_d     = s_c;
      s1_c_d     = c_c;
      s1_e_d     = apx_en ? e_c : '0;
      s1_fix_d   = apx_en ? '0  : e_c;
      s1_h_d     = h_c;
    end
  end

  // Stage 2: final carry-propagate add and error magnitude
  always_comb begin
    out_valid_d = out_valid_q;
    sum_d       = sum_q;
    err_mag_d   = err_mag_q;
    err_any_d   = err_any_q;
    if (adv_c) begin
      out_valid_d = s1_valid_q;
      sum_d       = (SUM_W'(s1_h_q) << APX_BITS) + SUM_W'(s1_s_q)
                  + (SUM_W'(s1_c_q) << 1) + (SUM_W'(s1_fix_q) << 1);
      err_mag_d   = ERR_W'(s1_e_q) << 1;
      err_any_d   = |s1_e_q;
    end
  end

  // Error-event counter: clear has priority, saturates at all-ones
  always_comb begin
    err_cnt_d = err_cnt_q;
    if (stat_clr) begin
      err_cnt_d = '0;
    end else if (out_valid_q && out_ready && err_any_q && (err_cnt_q != '1)) begin
      err_cnt_d = err_cnt_q + ERR_CNT_W'(1);
    end
  end

  // Pipeline and counter registers
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q  <= 1'b0;
      s1_s_q      <= '0;
      s1_c_q      <= '0;
      s1_e_q      <= '0;
      s1_fix_q    <= '0;
      s1_h_q      <= '0;
      out_valid_q <= 1'b0;
      sum_q       <= '0;
      err_mag_q   <= '0;
      err_any_q   <= 1'b0;
      err_cnt_q   <= '0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_s_q      <= s1_s_d;
      s1_c_q      <= s1_c_d;
      s1_e_q      <= s1_e_d;
      s1_fix_q    <= s1_fix_d;
      s1_h_q      <= s1_h_d;
      out_valid_q <= out_valid_d;
      sum_q       <= sum_d;
      err_mag_q   <= err_mag_d;
      err_any_q   <= err_any_d;
      err_cnt_q   <= err_cnt_d;
    end
  end

  assign out_valid = out_valid_q;
  assign sum       = sum_q;
  assign err_mag   = err_mag_q;
  assign err_any   = err_any_q;
  assign err_cnt   = err_cnt_q;

endmodule

// File: doc/apx_moa4_pipe.md
# apx_moa4_pipe

Parametrised, pipelined four-operand unsigned adder for the A-MOA datapath. The low `APX_BITS` columns are reduced by approximate 4:2 compressor cells; the upper columns are exact. Each result carries its exact error magnitude, and a saturating counter tracks erroneous results. It replaces single-column compressor instantiation in the multi-operand adder front end and has a valid/ready stream interface.

## Interface
- `W`, 16: operand width; at least 2.
- `APX_BITS`, 8: number of approximate low columns; 1..W.
- `ERR_CNT_W`, 16: width of the error-event counter.
- `clk`  in  1: the single clock; all state updates on its rising edge.
- `rst`  in  1: reset, synchronous, active-high.
- `in_valid`  in  1: operand beat valid.
- `in_ready`  out  1: block accepts a beat this cycle.
- `x1`, `x2`, `x3`, `x4`  in  W each: unsigned operands.
- `apx_en`  in  1: sampled with the beat. 1 selects approximate low columns; 0 makes all columns exact.
- `out_valid`  out  1: result valid.
- `out_ready`  in  1: downstream accepts the result.
- `sum`  out  W+2: approximate sum.
- `err_mag`  out  APX_BITS+1: exact sum minus `sum`; always ≥ 0.
- `err_any`  out  1: high when `err_mag` ≠ 0.
- `stat_clr`  in  1: synchronous clear of `err_cnt`.
- `err_cnt`  out  ERR_CNT_W: saturating count of delivered results with `err_any` = 1.

## Operation
- **Approximate cell, per column i < APX_BITS:**
  - p12 = x1^x2, p34 = x3^x4, g12 = x1&x2, g34 = x3&x4.
  - s = p12^p34; c = (p12&p34) | g12 | g34; e = g12&g34.
  - The cell is exact for column counts 0–3. For count 4 it yields 2 (s=0, c=1) and sets e.
- **Stage 1 (register S1):**
  - Per approximate column: s_i, c_i, e_i.
  - High part H = x1[W-1:APX_BITS] + ... + x4[W-1:APX_BITS], exact, width W-APX_BITS+2.
  - When `apx_en` = 0, the exact column-count path is used: all e_i = 0 and the low result is exact.
- **Stage 2 (register S2):**
  - sum = (H << APX_BITS) + S + (C << 1), where S = {s_i} and C = {c_i}, computed at width W+2.
  - err_mag = Σ e_i · 2^(i+1).
  - err_any = OR of e_i.
- **Invariant:** sum + err_mag = x1+x2+x3+x4 exactly, for every beat.
- **err_cnt:**
  - Increments by 1 on each output handshake (out_valid & out_ready) with err_any = 1.
  - Saturates at 2^ERR_CNT_W − 1.
  - If stat_clr is high in the same cycle as a counted handshake, clear wins and the result is 0; that event is dropped.

## Timing
- Latency: 2 cycles from input handshake to out_valid, when there is no stall.
- Throughput: one beat per cycle.
- Pipeline advance: adv = !out_valid | out_ready; in_ready = adv.
  - Both stages shift only when adv = 1.
  - Bubbles are not collapsed.
- While out_valid = 1 and out_ready = 0, `sum`, `err_mag` and `err_any` hold stable. No beat is lost or duplicated, and order is preserved.
- in_ready is combinational from out_valid and out_ready; there is no path from in_valid.
- Reset (any cycle, including mid-stream):
  - S1 and S2 valid bits clear, so out_valid = 0 in the next cycle.
  - `sum`, `err_mag`, `err_any` and `err_cnt` = 0.
  - in_ready = 1 from the first cycle after reset.
  - In-flight beats are discarded.
- Data registers update only on advance; the valid bits alone define occupancy.

## Structure
- Shared package `amoa_pkg`:
  - Function `apx_err_w(APX_BITS)` = APX_BITS+1.
  - Function `sum_w(W)` = W+2.
  - Cell-output struct: s, c, e.
- Sub-module `apx_cprs42_cell`: the combinational approximate cell (4 inputs; s, c, e outputs), instantiated APX_BITS times via generate.
- The pipeline registers, the adder and the counter stay in the top module.

## Test plan
All cases use W=8, APX_BITS=4.
1. **Exact mode.** apx_en=0, all operands 0xFF → two cycles later: sum=0x3FC, err_mag=0, err_any=0.
2. **Worst-case approximation.** apx_en=1, all operands 0x0F → sum=0x01E, err_mag=0x1E, err_any=1, err_cnt=1 after the handshake.
3. **Disjoint bits.** apx_en=1, operands 0x01, 0x02, 0x04, 0x08 → sum=0x00F, err_mag=0. Also run random operands for 10k beats and check the invariant sum + err_mag = exact sum.
4. **Backpressure.** Push 3 beats back-to-back with out_ready=0 for 4 cycles → in_ready drops after 2 beats, outputs stay stable, and all 3 results emerge in order once out_ready=1.
5. **Counter saturation and clear.** ERR_CNT_W=2, deliver 5 erroneous results → err_cnt=3. Then assert stat_clr together with an erroneous handshake → err_cnt=0.
6. **Reset mid-stream.** Assert rst for 1 cycle with both stages full → out_valid=0 and err_cnt=0 the next cycle, in_ready=1, and no stale result appears afterwards.
